data_mem_ctrl: RTL and testbench
================================

Name: data_mem_ctrl

Overview:
- Multi-cycle data-memory controller sitting directly downstream of the CPU datapath's memory stage.
- Consumes address (ALU-out register), store data (register read port B) and the mRD/mWR strobes from the control unit.
- Performs the word access after a configurable wait latency, then returns load data plus a done pulse to the DB-data mux path.
- busy output lets the control-unit FSM hold its MEM state until the access completes.

Parameters:
- DEPTH, 64, number of 32-bit words in the array; power of two, 4..4096.
- WAIT_CYCLES, 2, extra wait states per access, 0..15.
- IDX_W, $clog2(DEPTH), word-index width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- mRD  input  1  read request strobe, sampled in IDLE only
- mWR  input  1  write request strobe, sampled in IDLE only
- addr  input  32  byte address
- wdata  input  32  store data
- rdata  output  32  load data, registered
- busy  output  1  access in progress, request not accepted
- done  output  1  one-cycle completion pulse
- err  output  1  misaligned-access flag; valid in the done cycle

Behaviour:
- Reset (reset=0, asynchronous): state IDLE, busy=0, done=0, err=0, rdata=0, wait counter=0. Array contents are not reset.
- Reset mid-access aborts the access. A pending write is discarded and the array is unchanged.
- FSM states: IDLE, WAIT, DONE.
- IDLE:
  - On a rising edge with mRD|mWR=1: latch addr, wdata and op; load counter with WAIT_CYCLES; go to WAIT.
  - If both strobes are high, the access is a write; the read is ignored.
- WAIT:
  - busy=1. Counter decrements each cycle.
  - When the counter is 0 at an edge: go to DONE; perform a write commit or capture rdata on that same edge.
- DONE:
  - done=1 and busy=0 for exactly one cycle, then unconditionally back to IDLE.
  - Strobes in DONE are ignored; the control unit must re-issue in the following cycle.
- Latency: request sampled at edge N, done high during cycle N+WAIT_CYCLES+1. WAIT_CYCLES=0 gives one WAIT cycle.
- Strobes while busy are ignored, not queued.
- Word index = addr[IDX_W+1:2]. Upper address bits are ignored, so addresses wrap modulo DEPTH*4.
- rdata holds its value until the next read completes. Writes never change rdata.
- Read after a completed write to the same word returns the new data. No bypass is needed because accesses are serialised.

Optional Feature:
- Macro: DMEM_ALIGN_CHECK_EN
- Defined:
  - addr[1:0]!=0 at accept marks the access misaligned.
  - Latency is unchanged.
  - No array write; rdata is unchanged.
  - err=1 during the done cycle, 0 otherwise.
- Undefined: addr[1:0] is ignored and err is tied to 0.

Decomposition:
- Package dmem_pkg holds:
  - the state enum (IDLE/WAIT/DONE);
  - WORD_BYTES=4;
  - WAIT_W=4 (counter width);
  - the OP_RD/OP_WR encoding.
- One natural sub-module: dmem_array, a synchronous single-port word RAM.
  - Inputs: clk, we, idx, din. Output: registered dout.
  - No reset.
  - Controller instantiates it once.

Test Plan:
- Reset release, then mWR=1 at addr=0x10 with wdata=0xDEADBEEF (WAIT_CYCLES=2) -> busy high for 3 cycles; done pulses at N+3; err=0.
- mRD=1 at addr=0x10 after that write -> rdata=0xDEADBEEF coincident with done; rdata holds through subsequent idle cycles.
- Wrap check: write 0x12345678 to addr=0x100 (DEPTH=64), read addr=0x000 -> rdata=0x12345678.
- mRD re-asserted during WAIT, and mRD=mWR=1 in IDLE -> the WAIT-cycle strobe is ignored; the dual strobe performs only the write, rdata unchanged.
- reset driven low mid-WAIT of a write of 0xCAFEF00D to addr=0x20 -> busy/done go to 0 immediately; a later read of 0x20 returns the old value.
- With DMEM_ALIGN_CHECK_EN, mWR at addr=0x22 -> done at N+3 with err=1, array word 8 unchanged. Without the macro -> word 8 is written and err=0.

Source files
------------

// File: rtl/dmem_pkg.sv
// ============================================================================
// Module   : dmem_pkg
// Purpose  : Shared types and constants for the data-memory controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package dmem_pkg;

  localparam int WORD_BYTES = 4;
  localparam int WAIT_W     = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_t;

endpackage

`default_nettype wire

// File: rtl/dmem_array.sv
// ============================================================================
// Module   : dmem_array
// Purpose  : Synchronous single-port word RAM, registered read, no reset.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_array #(
  parameter int DEPTH = 64,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] idx,
  input  logic [31:0]      din,
  output logic [31:0]      dout
);

  logic [31:0] r_mem [DEPTH];

  // Read-before-write: dout shows the old word on the edge a write lands.
  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[idx] <= din;
    end
    dout <= r_mem[idx];
  end

endmodule

`default_nettype wire

// File: rtl/data_mem_ctrl.sv
// ============================================================================
// Module   : data_mem_ctrl
// Purpose  : Multi-cycle data-memory controller with programmable wait states.
//            Define DMEM_ALIGN_CHECK_EN to flag and suppress misaligned accesses.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module data_mem_ctrl
  import dmem_pkg::*;
#(
  parameter  int DEPTH       = 64,
  parameter  int WAIT_CYCLES = 2,
  localparam int IDX_W       = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mRD,
  input  logic        mWR,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int                c_lsb  = $clog2(WORD_BYTES);
  localparam logic [WAIT_W-1:0] c_wait = WAIT_W'(WAIT_CYCLES);

  state_t             r_state;
  op_t                r_op;
  logic [WAIT_W-1:0]  r_cnt;
  logic [IDX_W-1:0]   r_idx;
  logic [31:0]        r_wdata;
  logic [31:0]        r_rdata;
  logic               r_mis;
  logic               r_busy;
  logic               r_done;
  logic               r_err;

  logic               w_mis_in;
  logic               w_we;
  logic               w_rd_fresh;
  logic [31:0]        w_dout;
  logic               w_unused_addr;

`ifdef DMEM_ALIGN_CHECK_EN
  assign w_mis_in = (addr[c_lsb-1:0] != '0);
`else
  assign w_mis_in = 1'b0;
`endif

  // Upper bits wrap the array; low bits only matter to the alignment check.
  assign w_unused_addr = ^{addr[31:IDX_W+c_lsb], addr[c_lsb-1:0]};

  assign w_we       = (r_state == WAIT) && (r_cnt == '0) && (r_op == OP_WR) && !r_mis;
  assign w_rd_fresh = (r_state == DONE) && (r_op == OP_RD) && !r_mis;

  dmem_array #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_array (
    .clk  (clk),
    .we   (w_we),
    .idx  (r_idx),
    .din  (r_wdata),
    .dout (w_dout)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_op    <= OP_RD;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_mis   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          r_err  <= 1'b0;
          if (mRD || mWR) begin
            r_idx   <= addr[IDX_W+c_lsb-1:c_lsb];
            r_wdata <= wdata;
            r_op    <= mWR ? OP_WR : OP_RD;
            r_mis   <= w_mis_in;
            r_cnt   <= c_wait;
            r_busy  <= 1'b1;
            r_state <= WAIT;
          end
        end
        WAIT: begin
          if (r_cnt == '0) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_err   <= r_mis;
            r_state <= DONE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        DONE: begin
          // Array output is live this cycle; latch it so rdata holds afterwards.
          if (w_rd_fresh) begin
            r_rdata <= w_dout;
          end
          r_done  <= 1'b0;
          r_err   <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_err   <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign rdata = w_rd_fresh ? w_dout : r_rdata;
  assign busy  = r_busy;
  assign done  = r_done;
  assign err   = r_err;

endmodule

`default_nettype wire

// File: tb/tb_data_mem_ctrl.sv
// ============================================================================
// Module   : tb_data_mem_ctrl
// Purpose  : Directed self-checking bench for data_mem_ctrl (DEPTH=64, WAIT_CYCLES=2).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_data_mem_ctrl;

`ifdef DMEM_ALIGN_CHECK_EN
  localparam logic c_aln = 1'b1;
`else
  localparam logic c_aln = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        mRD;
  logic        mWR;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        busy;
  logic        done;
  logic        err;

  int total;
  int bad;

  data_mem_ctrl #(
    .DEPTH       (64),
    .WAIT_CYCLES (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .mRD   (mRD),
    .mWR   (mWR),
    .addr  (addr),
    .wdata (wdata),
    .rdata (rdata),
    .busy  (busy),
    .done  (done),
    .err   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one request from IDLE and checks the full busy/done timeline.
  // poke re-asserts mRD during WAIT and during DONE; both must be ignored.
  task automatic access(input string tag, input logic rd, input logic wr,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic exp_err, input logic [31:0] exp_rd,
                        input logic poke);
    mRD = rd; mWR = wr; addr = a; wdata = d;
    tick();
    mRD = 1'b0; mWR = 1'b0;
    check({tag, ".busy1"}, 32'(busy), 32'd1);
    check({tag, ".done1"}, 32'(done), 32'd0);
    tick();
    check({tag, ".busy2"}, 32'(busy), 32'd1);
    if (poke) mRD = 1'b1;
    tick();
    mRD = 1'b0;
    check({tag, ".busy3"}, 32'(busy), 32'd1);
    check({tag, ".done3"}, 32'(done), 32'd0);
    tick();
    check({tag, ".busy4"}, 32'(busy), 32'd0);
    check({tag, ".done4"}, 32'(done), 32'd1);
    check({tag, ".err"},   32'(err),  32'(exp_err));
    check({tag, ".rdata"}, rdata, exp_rd);
    if (poke) mRD = 1'b1;
    tick();
    mRD = 1'b0;
    check({tag, ".busy5"}, 32'(busy), 32'd0);
    check({tag, ".done5"}, 32'(done), 32'd0);
    check({tag, ".err5"},  32'(err),  32'd0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b0;
    mRD   = 1'b0;
    mWR   = 1'b0;
    addr  = '0;
    wdata = '0;
    #2;
    check("rst.busy",  32'(busy), 32'd0);
    check("rst.done",  32'(done), 32'd0);
    check("rst.err",   32'(err),  32'd0);
    check("rst.rdata", rdata,     32'd0);
    tick();
    reset = 1'b1;
    tick();

    access("wr10", 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0, 1'b0);
    access("rd10", 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold", rdata, 32'hDEADBEEF);
    end

    access("wr100", 1'b0, 1'b1, 32'h100, 32'h12345678, 1'b0, 32'hDEADBEEF, 1'b0);
    access("rd000", 1'b1, 1'b0, 32'h000, 32'h0, 1'b0, 32'h12345678, 1'b0);

    access("rdpoke", 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF, 1'b1);
    access("dual",   1'b1, 1'b1, 32'h10, 32'hA5A5A5A5, 1'b0, 32'hDEADBEEF, 1'b0);
    access("rddual", 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 32'hA5A5A5A5, 1'b0);

    access("wr20", 1'b0, 1'b1, 32'h20, 32'h11111111, 1'b0, 32'hA5A5A5A5, 1'b0);
    mWR = 1'b1; addr = 32'h20; wdata = 32'hCAFEF00D;
    tick();
    mWR = 1'b0;
    tick();
    check("abort.busy_pre", 32'(busy), 32'd1);
    reset = 1'b0;
    #1;
    check("abort.busy",  32'(busy), 32'd0);
    check("abort.done",  32'(done), 32'd0);
    check("abort.rdata", rdata,     32'd0);
    tick();
    reset = 1'b1;
    tick();
    access("rd20", 1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 32'h11111111, 1'b0);

    access("wr22", 1'b0, 1'b1, 32'h22, 32'h55AA55AA, c_aln, 32'h11111111, 1'b0);
    access("rd20b", 1'b1, 1'b0, 32'h20, 32'h0, 1'b0,
           c_aln ? 32'h11111111 : 32'h55AA55AA, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
